// File: rtl/wartezustand_ram_pkg.sv
// Shared types and constants for the wait-state RAM.
// Holds the control FSM state encoding and the wait counter width.
package wartezustand_ram_pkg;

  typedef enum logic [1:0] {
    LEERLAUF  = 2'd0,
    WARTEN    = 2'd1,
    ABSCHLUSS = 2'd2,
    LADEN     = 2'd3
  } zustand_t;

  localparam int unsigned ZAEHLERBREITE = 4;

endpackage

// File: rtl/wartezustand_ram_speicher_array.sv
// Single-port-write word array with a registered read port.
// Reads of indices beyond WORDS return zero instead of touching storage.
module speicher_array #(
  parameter int unsigned WORDSIZE = 32,
  parameter int unsigned WORDS    = 256,
  parameter int unsigned AW       = 8
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [WORDSIZE-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic [WORDSIZE-1:0] rdata
);

  logic [WORDSIZE-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= (32'(raddr) < WORDS) ? mem[raddr] : '0;
  end

endmodule

// File: rtl/wartezustand_ram.sv
// RAM with configurable wait states, four-phase CPU handshake and a streaming loader.
// Out-of-range accesses complete normally but raise Adressfehler and never touch storage.
module wartezustand_ram
  import wartezustand_ram_pkg::*;
#(
  parameter int unsigned WORDSIZE     = 32,
  parameter int unsigned WORDS        = 256,
  parameter int unsigned ADRESSBREITE = 32,
  parameter int unsigned WARTEZYKLEN  = 2
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    LeseDaten,
  input  logic                    SchreibeDaten,
  input  logic [ADRESSBREITE-1:0] Adresse,
  input  logic [WORDSIZE-1:0]     DatenRein,
  output logic [WORDSIZE-1:0]     DatenRaus,
  output logic                    DatenGeladen,
  output logic                    DatenGespeichert,
  output logic                    Adressfehler,
  input  logic                    LadeAn,
  input  logic                    LadeGueltig,
  input  logic [WORDSIZE-1:0]     LadeDaten,
  output logic                    LadeUeberlauf,
  output logic                    Beschaeftigt
);

  localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  zustand_t                 zustand;
  logic [ZAEHLERBREITE-1:0] zaehler;
  logic [ADRESSBREITE-1:0]  adresse_q;
  logic [WORDSIZE-1:0]      daten_q;
  logic                     schreiben_q;
  logic [AW-1:0]            lade_zeiger;

  logic                     ausserhalb;
  logic                     fertig;
  logic                     we;
  logic [AW-1:0]            waddr;
  logic [WORDSIZE-1:0]      wdata;
  logic [AW-1:0]            raddr;
  logic [WORDSIZE-1:0]      rdata;

  assign ausserhalb   = 64'(adresse_q) >= 64'(WORDS);
  assign fertig       = (zustand == WARTEN) && (zaehler == '0);
  assign Beschaeftigt = (zustand != LEERLAUF);

  // Read address follows the live Adresse while idle so that the array output already
  // holds the addressed word at the completion edge, even with zero wait states.
  always_comb begin
    we    = 1'b0;
    waddr = lade_zeiger;
    wdata = LadeDaten;
    raddr = (zustand == LEERLAUF) ? Adresse[AW-1:0] : adresse_q[AW-1:0];
    if (!Reset) begin
      if (zustand == LADEN && LadeGueltig) begin
        we = 1'b1;
      end else if (fertig && schreiben_q && !ausserhalb) begin
        we    = 1'b1;
        waddr = adresse_q[AW-1:0];
        wdata = daten_q;
      end
    end
  end

  speicher_array #(
    .WORDSIZE (WORDSIZE),
    .WORDS    (WORDS),
    .AW       (AW)
  ) u_speicher (
    .clk   (Clock),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand          <= LEERLAUF;
      zaehler          <= '0;
      lade_zeiger      <= '0;
      LadeUeberlauf    <= 1'b0;
      DatenRaus        <= '0;
      DatenGeladen     <= 1'b0;
      DatenGespeichert <= 1'b0;
      Adressfehler     <= 1'b0;
    end else begin
      unique case (zustand)
        LEERLAUF: begin
          if (LadeAn) begin
            zustand <= LADEN;
          end else if (SchreibeDaten || LeseDaten) begin
            adresse_q   <= Adresse;
            daten_q     <= DatenRein;
            schreiben_q <= SchreibeDaten;
            zaehler     <= ZAEHLERBREITE'(WARTEZYKLEN);
            zustand     <= WARTEN;
          end
        end
        WARTEN: begin
          if (zaehler == '0) begin
            if (schreiben_q) begin
              DatenGespeichert <= 1'b1;
            end else begin
              DatenGeladen <= 1'b1;
              DatenRaus    <= ausserhalb ? '0 : rdata;
            end
            Adressfehler <= ausserhalb;
            zustand      <= ABSCHLUSS;
          end else begin
            zaehler <= zaehler - ZAEHLERBREITE'(1);
          end
        end
        ABSCHLUSS: begin
          if (!LeseDaten && !SchreibeDaten) begin
            DatenGeladen     <= 1'b0;
            DatenGespeichert <= 1'b0;
            Adressfehler     <= 1'b0;
            zustand          <= LEERLAUF;
          end
        end
        LADEN: begin
          if (LadeGueltig) begin
            if (lade_zeiger == AW'(WORDS - 1)) begin
              lade_zeiger   <= '0;
              LadeUeberlauf <= 1'b1;
            end else begin
              lade_zeiger <= lade_zeiger + AW'(1);
            end
          end
          if (!LadeAn) begin
            zustand <= LEERLAUF;
          end
        end
        default: zustand <= LEERLAUF;
      endcase
    end
  end

endmodule

// File: tb/tb_wartezustand_ram.sv
// Randomised self-checking bench for wartezustand_ram against a word-array reference model.
module tb_wartezustand_ram;

  localparam int WS  = 32;
  localparam int NW  = 256;
  localparam int AB  = 32;
  localparam int WZ  = 2;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          LeseDaten = 1'b0;
  logic          SchreibeDaten = 1'b0;
  logic [AB-1:0] Adresse = '0;
  logic [WS-1:0] DatenRein = '0;
  logic [WS-1:0] DatenRaus;
  logic          DatenGeladen;
  logic          DatenGespeichert;
  logic          Adressfehler;
  logic          LadeAn = 1'b0;
  logic          LadeGueltig = 1'b0;
  logic [WS-1:0] LadeDaten = '0;
  logic          LadeUeberlauf;
  logic          Beschaeftigt;

  wartezustand_ram #(
    .WORDSIZE     (WS),
    .WORDS        (NW),
    .ADRESSBREITE (AB),
    .WARTEZYKLEN  (WZ)
  ) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .LeseDaten        (LeseDaten),
    .SchreibeDaten    (SchreibeDaten),
    .Adresse          (Adresse),
    .DatenRein        (DatenRein),
    .DatenRaus        (DatenRaus),
    .DatenGeladen     (DatenGeladen),
    .DatenGespeichert (DatenGespeichert),
    .Adressfehler     (Adressfehler),
    .LadeAn           (LadeAn),
    .LadeGueltig      (LadeGueltig),
    .LadeDaten        (LadeDaten),
    .LadeUeberlauf    (LadeUeberlauf),
    .Beschaeftigt     (Beschaeftigt)
  );

  always #5 Clock = ~Clock;

  // Reference model
  logic [WS-1:0] ref_mem [NW];
  logic [WS-1:0] last_read = '0;
  int            ref_ptr = 0;
  bit            ref_ovf = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    LeseDaten = 1'b0;
    SchreibeDaten = 1'b0;
    LadeAn = 1'b0;
    LadeGueltig = 1'b0;
    tick();
    Reset = 1'b0;
    ref_ptr = 0;
    ref_ovf = 1'b0;
    last_read = '0;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({DatenRaus, DatenGeladen, DatenGespeichert, Adressfehler, LadeUeberlauf, Beschaeftigt}
        !== {WS'(0), 5'b0}) begin
      errors++;
      $display("FAIL %s: outputs raus=%h gel=%b gesp=%b fehler=%b ovf=%b busy=%b, required all 0",
               name, DatenRaus, DatenGeladen, DatenGespeichert, Adressfehler, LadeUeberlauf,
               Beschaeftigt);
    end
  endtask

  // One complete CPU access including the four-phase release.
  task automatic access(input bit wr, input bit rd, input logic [AB-1:0] addr,
                        input logic [WS-1:0] din, input string name);
    bit is_wr;
    bit oor;
    bit got;
    int lat;
    int hold;
    is_wr = wr;
    oor   = (addr >= AB'(NW));
    if (is_wr) begin
      if (!oor) ref_mem[addr[7:0]] = din;
    end else begin
      last_read = oor ? '0 : ref_mem[addr[7:0]];
    end
    SchreibeDaten = wr;
    LeseDaten = rd;
    Adresse = addr;
    DatenRein = din;
    lat = 0;
    got = 1'b0;
    while (lat < 40 && !got) begin
      tick();
      lat++;
      Adresse = $urandom;
      DatenRein = $urandom;
      if (DatenGeladen || DatenGespeichert) got = 1'b1;
    end
    checks++;
    if (!got || lat != WZ + 2) begin
      errors++;
      $display("FAIL %s latency: got %0d edges (ack=%b), required %0d", name, lat, got, WZ + 2);
    end
    hold = $urandom_range(1, 3);
    for (int h = 0; h <= hold; h++) begin
      checks++;
      if ({DatenGeladen, DatenGespeichert, Adressfehler, Beschaeftigt} !==
          {!is_wr, is_wr, oor, 1'b1} || DatenRaus !== last_read) begin
        errors++;
        $display("FAIL %s ack: gel=%b gesp=%b fehler=%b busy=%b raus=%h, required %b %b %b 1 %h",
                 name, DatenGeladen, DatenGespeichert, Adressfehler, Beschaeftigt, DatenRaus,
                 !is_wr, is_wr, oor, last_read);
      end
      if (h < hold) tick();
    end
    LeseDaten = 1'b0;
    SchreibeDaten = 1'b0;
    tick();
    checks++;
    if ({DatenGeladen, DatenGespeichert, Adressfehler, Beschaeftigt} !== 4'b0 ||
        DatenRaus !== last_read) begin
      errors++;
      $display("FAIL %s release: gel=%b gesp=%b fehler=%b busy=%b raus=%h, required 0 0 0 0 %h",
               name, DatenGeladen, DatenGespeichert, Adressfehler, Beschaeftigt, DatenRaus,
               last_read);
    end
  endtask

  // Stream n words; the last word is sent in the same cycle LadeAn drops.
  task automatic load(input int n, input bit seq, input string name);
    logic [WS-1:0] v;
    LadeAn = 1'b1;
    LadeGueltig = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        LadeGueltig = 1'b0;
        SchreibeDaten = 1'b1;
        tick();
        checks++;
        if (DatenGespeichert !== 1'b0 || Beschaeftigt !== 1'b1) begin
          errors++;
          $display("FAIL %s loader isolation: gesp=%b busy=%b, required 0 1",
                   name, DatenGespeichert, Beschaeftigt);
        end
      end
      v = seq ? WS'(i) : WS'($urandom);
      SchreibeDaten = (i != n - 1);
      LadeGueltig = 1'b1;
      LadeDaten = v;
      if (i == n - 1) LadeAn = 1'b0;
      tick();
      ref_mem[ref_ptr] = v;
      if (ref_ptr == NW - 1) begin
        ref_ptr = 0;
        ref_ovf = 1'b1;
      end else begin
        ref_ptr++;
      end
    end
    LadeGueltig = 1'b0;
    SchreibeDaten = 1'b0;
    tick();
    checks++;
    if (LadeUeberlauf !== ref_ovf || Beschaeftigt !== 1'b0 || DatenGespeichert !== 1'b0) begin
      errors++;
      $display("FAIL %s loader end: ovf=%b busy=%b gesp=%b, required %b 0 0",
               name, LadeUeberlauf, Beschaeftigt, DatenGespeichert, ref_ovf);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    check_idle_outputs("reset");
  endtask

  task automatic test_load_fill();
    load(NW, 1'b0, "fill");
  endtask

  task automatic test_read_latency();
    access(1'b1, 1'b0, 5, 32'hDEADBEEF, "preload5");
    access(1'b0, 1'b1, 5, 0, "read5");
    checks++;
    if (DatenRaus !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read5 data: got %h, required deadbeef", DatenRaus);
    end
  endtask

  task automatic test_write_read();
    access(1'b1, 1'b0, 7, 32'h12345678, "write7");
    access(1'b0, 1'b1, 7, 0, "read7");
    checks++;
    if (DatenRaus !== 32'h12345678) begin
      errors++;
      $display("FAIL read7 data: got %h, required 12345678", DatenRaus);
    end
  endtask

  task automatic test_simultaneous();
    access(1'b1, 1'b1, 9, 1, "both9");
    access(1'b0, 1'b1, 9, 0, "read9");
    checks++;
    if (DatenRaus !== 32'h1) begin
      errors++;
      $display("FAIL read9 data: got %h, required 1", DatenRaus);
    end
  endtask

  task automatic test_out_of_range();
    access(1'b0, 1'b1, 300, 0, "read300");
    access(1'b1, 1'b0, 300, $urandom, "write300");
    access(1'b1, 1'b0, 32'hFFFF_FF00, $urandom, "writehigh");
    for (int a = 0; a < NW; a++) access(1'b0, 1'b1, a, 0, "sweep");
  endtask

  task automatic test_random();
    int a;
    int k;
    for (int i = 0; i < 30; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 256 + $urandom_range(0, 99) : $urandom_range(0, 255);
      k = $urandom_range(0, 2);
      access(k != 1, k != 0, a, $urandom, "random");
    end
  endtask

  task automatic test_reset_mid_write();
    SchreibeDaten = 1'b1;
    Adresse = 4;
    DatenRein = ~ref_mem[4];
    tick();
    tick();
    Reset = 1'b1;
    SchreibeDaten = 1'b0;
    tick();
    Reset = 1'b0;
    ref_ptr = 0;
    ref_ovf = 1'b0;
    last_read = '0;
    check_idle_outputs("reset_mid_write");
    access(1'b0, 1'b1, 4, 0, "read4_after_reset");
  endtask

  task automatic test_loader_resume();
    apply_reset();
    load(3, 1'b0, "resume_a");
    load(2, 1'b0, "resume_b");
    for (int a = 0; a < 6; a++) access(1'b0, 1'b1, a, 0, "resume_read");
  endtask

  task automatic test_loader_wrap();
    apply_reset();
    load(257, 1'b1, "wrap");
    access(1'b0, 1'b1, 0, 0, "wrap_read0");
    checks++;
    if (DatenRaus !== 32'd256) begin
      errors++;
      $display("FAIL wrap word0: got %h, required 100", DatenRaus);
    end
    access(1'b0, 1'b1, 1, 0, "wrap_read1");
    checks++;
    if (DatenRaus !== 32'd1 || LadeUeberlauf !== 1'b1) begin
      errors++;
      $display("FAIL wrap word1/ovf: got %h ovf=%b, required 1 ovf=1", DatenRaus, LadeUeberlauf);
    end
  endtask

  initial begin
    test_reset();
    test_load_fill();
    test_read_latency();
    test_write_read();
    test_simultaneous();
    test_out_of_range();
    test_random();
    test_reset_mid_write();
    test_loader_resume();
    test_loader_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wartezustand_ram.md
Name: wartezustand_ram

Overview:
- Parametrised successor of the plain single-port RAM that the CPU data and instruction ports connect to.
- Adds configurable wait states and a real four-phase handshake. The handshake drives the CPU's DatenGeladen/DatenGespeichert/InstruktionGeladen inputs, which are no longer tied high.
- Adds a streaming loader port, so a bench or boot ROM fills memory without an external address mux.
- Out-of-range accesses are reported to the requester instead of aliasing.

Parameters:
- WORDSIZE, 32, data word width in bits.
- WORDS, 256, number of words; any value >= 2.
- ADRESSBREITE, 32, width of the Adresse port.
- WARTEZYKLEN, 2, extra cycles between acceptance and completion; 0..15.

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- LeseDaten  in  1  read request, held until handshake.
- SchreibeDaten  in  1  write request, held until handshake.
- Adresse  in  ADRESSBREITE  word address.
- DatenRein  in  WORDSIZE  write data.
- DatenRaus  out  WORDSIZE  read data; valid while DatenGeladen = 1.
- DatenGeladen  out  1  read-complete acknowledge.
- DatenGespeichert  out  1  write-complete acknowledge.
- Adressfehler  out  1  current acknowledge is for an address >= WORDS.
- LadeAn  in  1  loader mode request.
- LadeGueltig  in  1  LadeDaten valid this cycle.
- LadeDaten  in  WORDSIZE  loader word.
- LadeUeberlauf  out  1  sticky: loader pointer wrapped past WORDS-1.
- Beschaeftigt  out  1  FSM not in LEERLAUF.

Behaviour:
- Reset
  - One clock; reset is synchronous and active-high.
  - All outputs go to 0, FSM to LEERLAUF, load pointer to 0, LadeUeberlauf to 0.
  - Memory contents are not cleared.
  - Reset mid-access aborts it. A write not yet committed is discarded.
- States: LEERLAUF, WARTEN, ABSCHLUSS, LADEN.
- LEERLAUF
  - Priority is LadeAn, then SchreibeDaten, then LeseDaten.
  - LadeAn = 1 goes to LADEN.
  - Otherwise a strobe latches Adresse, DatenRein and the direction, loads the wait counter with WARTEZYKLEN, and goes to WARTEN.
  - Both strobes high means the write wins; the read is not performed.
- WARTEN
  - Counter decrements each cycle. When the counter is 0, the completion edge fires and the FSM goes to ABSCHLUSS.
  - Latency: request accepted at edge N, acknowledge high after edge N+1+WARTEZYKLEN.
  - Strobes and Adresse are ignored after acceptance; the latched values are used.
- Completion edge
  - Write: the memory word is written unless the address is out of range.
  - Read: DatenRaus is loaded with the word, or 0 if out of range.
  - Adressfehler is set if the latched address >= WORDS.
- ABSCHLUSS (four-phase handshake)
  - The matching acknowledge is held at 1 until both strobes are 0.
  - The cycle after that, the acknowledge and Adressfehler drop and the FSM returns to LEERLAUF.
  - Each access requires strobe low before the next is accepted, so there is no double access.
  - DatenRaus holds its value until the next read completes.
- LADEN
  - Each cycle with LadeGueltig = 1, LadeDaten is written at the pointer and the pointer increments.
  - At WORDS-1 the pointer wraps to 0 and LadeUeberlauf sets (sticky until Reset).
  - CPU strobes are ignored; no acknowledges are given.
  - LadeAn = 0 returns to LEERLAUF next cycle; the pointer is kept, so a later load resumes.
  - LadeAn dropping in the same cycle as LadeGueltig still writes that word.
- Beschaeftigt = 1 in every state except LEERLAUF.

Decomposition:
- Shared package holds:
  - the state encoding constants,
  - a ZAEHLERBREITE constant (4 bits) for the wait counter.
- One sub-module, speicher_array: WORDS x WORDSIZE, one synchronous write port, registered read. It is used by the control FSM here and reusable by later caches.

Test Plan:
- Read latency, WARTEZYKLEN=2: preload word 5 = 32'hDEADBEEF, assert LeseDaten with Adresse=5 at edge 0. Required: DatenGeladen=1 and DatenRaus=32'hDEADBEEF after edge 3, held until LeseDaten drops, low one cycle later.
- Write then read: SchreibeDaten, Adresse=7, DatenRein=32'h12345678. Required: DatenGespeichert after edge 3. Then a read of 7 returns 32'h12345678.
- Simultaneous strobes: both high, Adresse=9, DatenRein=1. Required: only DatenGespeichert asserts and word 9 = 1.
- Out of range: read Adresse=300 with WORDS=256. Required: DatenRaus=0 and Adressfehler=1 with DatenGeladen. A write to 300 leaves all words unchanged.
- Loader wrap: stream 257 words 0..256 with LadeAn/LadeGueltig. Required: word 0 = 256, word 1 = 1, LadeUeberlauf=1.
- Reset mid-write: assert Reset in WARTEN during a write to 4. Required: word 4 unchanged, all outputs 0, next access accepted normally.
